// File: rtl/aq_djpeg_use_arbiter.sv
// Bitstream consume arbiter: grants header, restart-marker and Huffman requests
// as one-cycle Use strobes. Optional BitCount output under AQ_DJPEG_USEARB_BITCNT_EN.
module aq_djpeg_use_arbiter #(
    parameter int HUF_MAX_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ImageEnable,
    input  logic        DataOutEnable,
    input  logic        DataOutEnd,
    input  logic        hdr_req,
    input  logic [1:0]  hdr_type,
    output logic        hdr_ack,
    input  logic        huf_req,
    input  logic [6:0]  huf_width,
    output logic        huf_ack,
    input  logic        mrk_req,
    output logic        mrk_ack,
    output logic        UseBit,
    output logic        UseByte,
    output logic        UseWord,
    output logic        AlignByte,
    output logic [6:0]  UseWidth,
    output logic        Busy,
    output logic        Error
`ifdef AQ_DJPEG_USEARB_BITCNT_EN
    ,
    output logic [31:0] BitCount
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    localparam logic [6:0] HUF_MAX = 7'(HUF_MAX_WIDTH);

    state_t     state_q, state_d;
    logic       hdr_ack_q, hdr_ack_d;
    logic       huf_ack_q, huf_ack_d;
    logic       mrk_ack_q, mrk_ack_d;
    logic       use_bit_q, use_bit_d;
    logic       use_byte_q, use_byte_d;
    logic       use_word_q, use_word_d;
    logic       align_byte_q, align_byte_d;
    logic [6:0] use_width_q, use_width_d;
    logic       error_q, error_d;

    logic       qualify;
    logic       hdr_elig;
    logic       mrk_elig;
    logic       huf_elig;
    logic       huf_bad;

    assign qualify  = DataOutEnable & ~DataOutEnd;
    assign hdr_elig = hdr_req & ~ImageEnable;
    assign mrk_elig = mrk_req & ImageEnable;
    assign huf_elig = huf_req & ImageEnable;
    assign huf_bad  = (huf_width == 7'd0) || (huf_width > HUF_MAX);

    // The strobe/ack flops are the latched winner; they are loaded only on the
    // IDLE->ISSUE edge, so later input changes cannot alter an in-flight grant.
    always_comb begin
        state_d      = state_q;
        hdr_ack_d    = 1'b0;
        huf_ack_d    = 1'b0;
        mrk_ack_d    = 1'b0;
        use_bit_d    = 1'b0;
        use_byte_d   = 1'b0;
        use_word_d   = 1'b0;
        align_byte_d = 1'b0;
        use_width_d  = 7'd0;
        error_d      = error_q;

        case (state_q)
            IDLE: begin
                if (qualify && (hdr_elig || mrk_elig || huf_elig)) begin
                    state_d = ISSUE;
                    if (hdr_elig) begin
                        hdr_ack_d = 1'b1;
                        case (hdr_type)
                            2'b00:   use_byte_d   = 1'b1;
                            2'b01:   use_word_d   = 1'b1;
                            2'b10:   align_byte_d = 1'b1;
                            default: error_d      = 1'b1;
                        endcase
                    end else if (mrk_elig) begin
                        mrk_ack_d    = 1'b1;
                        align_byte_d = 1'b1;
                    end else begin
                        huf_ack_d = 1'b1;
                        if (huf_bad) begin
                            error_d = 1'b1;
                        end else begin
                            use_bit_d   = 1'b1;
                            use_width_d = huf_width;
                        end
                    end
                end
            end
            ISSUE:   state_d = SETTLE;
            SETTLE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            hdr_ack_q    <= 1'b0;
            huf_ack_q    <= 1'b0;
            mrk_ack_q    <= 1'b0;
            use_bit_q    <= 1'b0;
            use_byte_q   <= 1'b0;
            use_word_q   <= 1'b0;
            align_byte_q <= 1'b0;
            use_width_q  <= 7'd0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            hdr_ack_q    <= hdr_ack_d;
            huf_ack_q    <= huf_ack_d;
            mrk_ack_q    <= mrk_ack_d;
            use_bit_q    <= use_bit_d;
            use_byte_q   <= use_byte_d;
            use_word_q   <= use_word_d;
            align_byte_q <= align_byte_d;
            use_width_q  <= use_width_d;
            error_q      <= error_d;
        end
    end

    // Reset arriving while a grant is visible kills it immediately, so the
    // register-data block never consumes on the reset edge.
    assign hdr_ack   = hdr_ack_q & ~rst;
    assign huf_ack   = huf_ack_q & ~rst;
    assign mrk_ack   = mrk_ack_q & ~rst;
    assign UseBit    = use_bit_q & ~rst;
    assign UseByte   = use_byte_q & ~rst;
    assign UseWord   = use_word_q & ~rst;
    assign AlignByte = align_byte_q & ~rst;
    assign UseWidth  = use_width_q & {7{~rst}};
    assign Busy      = (state_q != IDLE);
    assign Error     = error_q;

`ifdef AQ_DJPEG_USEARB_BITCNT_EN
    logic        end_q;
    logic [31:0] bit_count_q, bit_count_d;
    logic [31:0] consumed;

    // A fresh EOI restarts the count; a clear on the same edge as a strobe wins.
    always_comb begin
        consumed = 32'd0;
        if (use_bit_q) begin
            consumed = {25'd0, use_width_q};
        end else if (use_word_q) begin
            consumed = 32'd16;
        end else if (use_byte_q) begin
            consumed = 32'd8;
        end
        bit_count_d = bit_count_q + consumed;
        if (DataOutEnd && !end_q) begin
            bit_count_d = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            end_q       <= 1'b0;
            bit_count_q <= 32'd0;
        end else begin
            end_q       <= DataOutEnd;
            bit_count_q <= bit_count_d;
        end
    end

    assign BitCount = bit_count_q;
`endif

endmodule
